clint_wishbone: RTL and testbench

Wishbone-B4 classic responder implementing the RISC-V CLINT timer and software-interrupt registers for the CVA5 LiteX SoC. It sits on the peripheral/data Wishbone bus that the core drives as initiator. It maintains the 64-bit `mtime` counter, `mtimecmp` and `msip`, and drives the core's `mtime`, `cpu_timer_in` and `cpu_software_in` inputs.

---
 rtl/clint_wishbone.sv | 143 ++++++++++++++
 tb/tb_clint_wishbone.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clint_wishbone.sv
// clint_wishbone: Wishbone-B4 classic responder with the RISC-V CLINT msip/mtimecmp/mtime registers.
// Define CLINT_PRESCALER_EN to tick mtime once every DIVIDER clocks instead of every clock.
module clint_wishbone #(
  parameter logic [31:0] BASE_ADDR = 32'hF0010000,
  parameter int unsigned DIVIDER   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic        wb_cti,
  input  logic        wb_bte,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        wb_err,
  output logic [63:0] mtime,
  output logic        cpu_timer_in,
  output logic        cpu_software_in
);

  localparam logic [13:0] OFF_MSIP   = 14'h0000;
  localparam logic [13:0] OFF_CMP_LO = 14'h1000;
  localparam logic [13:0] OFF_CMP_HI = 14'h1001;
  localparam logic [13:0] OFF_MT_LO  = 14'h2FFE;
  localparam logic [13:0] OFF_MT_HI  = 14'h2FFF;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_r_q, dat_r_d;
  logic        timer_q, timer_d;

  logic        tick;
  logic [13:0] off;
  logic        win_hit;
  logic        mapped;
  logic        req;
  logic        wr;
  logic [31:0] rdata;

  logic unused_ok;
  assign unused_ok = ^{wb_cti, wb_bte};

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

`ifdef CLINT_PRESCALER_EN
  logic [31:0] presc_q, presc_d;

  always_comb begin
    tick    = (presc_q == 32'(DIVIDER - 1));
    presc_d = tick ? 32'd0 : presc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= 32'd0;
    else     presc_q <= presc_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    off     = wb_adr[13:0];
    win_hit = (wb_adr[29:14] == BASE_ADDR[31:16]);
    mapped  = (off == OFF_MSIP) || (off == OFF_CMP_LO) || (off == OFF_CMP_HI) ||
              (off == OFF_MT_LO) || (off == OFF_MT_HI);
    // Holding off while a termination is on the bus makes each access exactly one ack.
    req     = wb_cyc & wb_stb & ~ack_q & ~err_q & win_hit;
    wr      = req & wb_we & mapped;

    case (off)
      OFF_MSIP:   rdata = {31'd0, msip_q};
      OFF_CMP_LO: rdata = mtimecmp_q[31:0];
      OFF_CMP_HI: rdata = mtimecmp_q[63:32];
      OFF_MT_LO:  rdata = mtime_q[31:0];
      OFF_MT_HI:  rdata = mtime_q[63:32];
      default:    rdata = 32'd0;
    endcase

    ack_d   = req & mapped;
    err_d   = req & ~mapped;
    dat_r_d = ack_d ? rdata : 32'd0;

    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q + {63'd0, tick};

    if (wr) begin
      case (off)
        OFF_MSIP:   if (wb_sel[0]) msip_d = wb_dat_w[0];
        OFF_CMP_LO: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wb_dat_w, wb_sel);
        OFF_CMP_HI: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wb_dat_w, wb_sel);
        // A bus write to mtime replaces that cycle's tick entirely.
        OFF_MT_LO:  mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wb_dat_w, wb_sel)};
        OFF_MT_HI:  mtime_d = {merge(mtime_q[63:32], wb_dat_w, wb_sel), mtime_q[31:0]};
        default:    ;
      endcase
    end

    timer_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_r_q    <= 32'd0;
      timer_q    <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_r_q    <= dat_r_d;
      timer_q    <= timer_d;
    end
  end

  assign wb_dat_r        = dat_r_q;
  assign wb_ack          = ack_q;
  assign wb_err          = err_q;
  assign mtime           = mtime_q;
  assign cpu_timer_in    = timer_q;
  assign cpu_software_in = msip_q;

endmodule

// File: tb/tb_clint_wishbone.sv
// Self-checking bench for clint_wishbone: register table plus timer, wrap, error and reset sequences.
module tb_clint_wishbone;

  localparam logic [31:0] BASE_ADDR = 32'hF0010000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] wb_adr = '0;
  logic [31:0] wb_dat_w = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic        wb_cti = 1'b0;
  logic        wb_bte = 1'b0;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;
  logic [63:0] mtime;
  logic        cpu_timer_in;
  logic        cpu_software_in;

  always #5 clk = ~clk;

  clint_wishbone #(
    .BASE_ADDR(BASE_ADDR)
`ifdef CLINT_PRESCALER_EN
    , .DIVIDER(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err), .mtime(mtime),
    .cpu_timer_in(cpu_timer_in), .cpu_software_in(cpu_software_in)
  );

  typedef struct {
    logic        exp_err;
    logic        chk;
    logic [31:0] exp_dat;
    string       name;
  } sb_t;

  typedef struct {
    logic [13:0] off;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        chk;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic        exp_sw;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[18];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One classic access; the response itself is scored by the monitor below.
  task automatic xfer(input logic [13:0] off, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, input logic chk, input logic [31:0] exp_dat,
                      input logic exp_err, input string name);
    sb_t e;
    @(posedge clk); #1;
    rst      = 1'b0;
    wb_adr   = {BASE_ADDR[31:16], off};
    wb_we    = we;
    wb_dat_w = dat;
    wb_sel   = sel;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    e.exp_err = exp_err;
    e.chk     = chk;
    e.exp_dat = exp_dat;
    e.name    = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    checks++;
    if (wb_ack || wb_err) passes++;
    else begin
      $display("FAIL %s_latency: got no termination expected ack/err one cycle after stb", name);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
  endtask

  always @(negedge clk) begin
    if (wb_ack || wb_err) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", wb_ack, wb_err);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check({e.name, "_resp"}, {62'd0, wb_ack, wb_err}, e.exp_err ? 64'd1 : 64'd2);
        if (e.chk) check({e.name, "_dat"}, {32'd0, wb_dat_r}, {32'd0, e.exp_dat});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{14'h2FFE, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{14'h1000, 1'b0, 32'h0,        4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2]  = '{14'h1001, 1'b0, 32'h0,        4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[3]  = '{14'h0000, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4]  = '{14'h2FFF, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5]  = '{14'h0004, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6]  = '{14'h0004, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{14'h0000, 1'b1, 32'hFFFFFFFF, 4'h1, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[8]  = '{14'h0000, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0001, 1'b0, 1'b1};
    vecs[9]  = '{14'h0000, 1'b1, 32'h0,        4'hE, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[10] = '{14'h0000, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0001, 1'b0, 1'b1};
    vecs[11] = '{14'h1000, 1'b1, 32'h0000AB00, 4'h2, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[12] = '{14'h1000, 1'b0, 32'h0,        4'hF, 1'b1, 32'hFFFF_ABFF, 1'b0, 1'b1};
    vecs[13] = '{14'h1001, 1'b1, 32'h12345678, 4'hC, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vecs[14] = '{14'h1001, 1'b0, 32'h0,        4'hF, 1'b1, 32'h1234_FFFF, 1'b0, 1'b1};
    vecs[15] = '{14'h0000, 1'b1, 32'h0,        4'h1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[16] = '{14'h0000, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[17] = '{14'h0FFF, 1'b0, 32'h0,        4'hF, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {63'd0, wb_ack}, 64'd0);
    check("rst_err", {63'd0, wb_err}, 64'd0);
    check("rst_dat", {32'd0, wb_dat_r}, 64'd0);
    check("rst_mtime", mtime, 64'd0);
    check("rst_timer", {63'd0, cpu_timer_in}, 64'd0);
    check("rst_sw", {63'd0, cpu_software_in}, 64'd0);

    // First access releases reset in the same cycle, so mtime low still reads 0.
    for (int i = 0; i < 18; i++) begin
      xfer(vecs[i].off, vecs[i].we, vecs[i].dat, vecs[i].sel, vecs[i].chk,
           vecs[i].exp_dat, vecs[i].exp_err, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_sw", i), {63'd0, cpu_software_in}, {63'd0, vecs[i].exp_sw});
    end

    @(posedge clk); #1;
    wb_adr = {16'hF002, 14'h0000};
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("miss_noresp", {62'd0, wb_ack, wb_err}, 64'd0);
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;

`ifdef CLINT_PRESCALER_EN
    xfer(14'h2FFF, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, "pre_wr_hi");
    xfer(14'h2FFE, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, "pre_wr_lo");
    check("pre_mtime0", mtime, 64'd0);
    repeat (16) @(posedge clk);
    #1;
    check("pre_mtime16", mtime, 64'd4);
`else
    xfer(14'h2FFF, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, "prio_wr_hi");
    xfer(14'h2FFE, 1'b1, 32'h5, 4'hF, 1'b0, 32'h0, 1'b0, "prio_wr_lo");
    check("prio_mtime", mtime, 64'd5);
    xfer(14'h2FFE, 1'b0, 32'h0, 4'hF, 1'b1, 32'd6, 1'b0, "free_rd0");
    repeat (8) @(posedge clk);
    xfer(14'h2FFE, 1'b0, 32'h0, 4'hF, 1'b1, 32'd16, 1'b0, "free_rd1");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("free_mtime%0d", k), mtime, 64'd17 + 64'(k));
      @(posedge clk); #1;
    end

    xfer(14'h1001, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, "cmp_wr_hi");
    xfer(14'h1000, 1'b1, 32'd100, 4'hF, 1'b0, 32'h0, 1'b0, "cmp_wr_lo");
    xfer(14'h2FFE, 1'b1, 32'd90, 4'hF, 1'b0, 32'h0, 1'b0, "tmr_wr_mt");
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      check($sformatf("tmr_mtime%0d", k), mtime, 64'd90 + 64'(k));
      check($sformatf("tmr_irq%0d", k), {63'd0, cpu_timer_in}, (k >= 11) ? 64'd1 : 64'd0);
    end
    xfer(14'h1001, 1'b1, 32'h1, 4'hF, 1'b0, 32'h0, 1'b0, "cmp_wr_hi1");
    check("tmr_fall_n1", {63'd0, cpu_timer_in}, 64'd1);
    @(posedge clk); #1;
    check("tmr_fall_n2", {63'd0, cpu_timer_in}, 64'd0);

    xfer(14'h2FFF, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b0, "wrap_wr_hi");
    xfer(14'h2FFE, 1'b1, 32'hFFFFFFFE, 4'hF, 1'b0, 32'h0, 1'b0, "wrap_wr_lo");
    check("wrap_t0", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk); #1;
    check("wrap_t1", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    check("wrap_t2", mtime, 64'd0);
    xfer(14'h2FFF, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0, "wrap_rd_hi");
`endif

    xfer(14'h0000, 1'b1, 32'h1, 4'h1, 1'b0, 32'h0, 1'b0, "rst_msip_set");
    check("rst_msip_set_sw", {63'd0, cpu_software_in}, 64'd1);
    @(posedge clk); #1;
    rst      = 1'b1;
    wb_adr   = {BASE_ADDR[31:16], 14'h1000};
    wb_we    = 1'b1;
    wb_dat_w = 32'h0;
    wb_sel   = 4'hF;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    @(posedge clk); #1;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    check("midrst_ack", {62'd0, wb_ack, wb_err}, 64'd0);
    check("midrst_sw", {63'd0, cpu_software_in}, 64'd0);
    check("midrst_mtime", mtime, 64'd0);
    xfer(14'h1000, 1'b0, 32'h0, 4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0, "midrst_cmp");
    check("midrst_timer", {63'd0, cpu_timer_in}, 64'd0);

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
